counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clock cycles per count increment (legal range 1..2^24).
REQ-002 SHALL have parameter SCAN_DIV, default 16: clock cycles per display digit slot (legal range 1..2^16).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ctrl, output, 4 bits: active-low one-hot digit enable; ctrl[0] is units, ctrl[3] is thousands.
REQ-006 SHALL have port segment, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}; bit 7 (dp) is always 1 (off).

Function
REQ-007 SHALL hold four BCD digits d3..d0 (value 0000..9999), each digit confined to 0..9.
REQ-008 SHALL run a prescaler counting 0..TICK_DIV-1 and wrapping to 0; the cycle it equals TICK_DIV-1 is the tick.
REQ-009 SHALL increment the BCD value by exactly 1 on each tick, with decimal carry: a digit at 9 becomes 0 and carries into the next digit.
REQ-010 SHALL wrap the count 9999 -> 0000 on the next tick, with no flag and no stall.
REQ-011 SHALL run a scan divider counting 0..SCAN_DIV-1; at terminal count, digit index 0..3 SHALL advance 0->1->2->3->0.
REQ-012 SHALL register ctrl and segment, updated every cycle from the current digit index and the current count.
REQ-013 SHALL drive ctrl low only on bit [idx], all other bits high, with segment showing digit d[idx].
REQ-014 SHALL use these segment codes for digits 0..9: C0,F9,A4,B0,99,92,82,F8,80,90 (hex); any non-BCD code SHALL show FF (blank).
REQ-015 SHALL let a tick and a scan advance in the same cycle take effect independently, with no lost increment.
REQ-016 SHALL use the count value from before the increment when a digit is displayed in the same cycle the count increments; the output lags state by 1 cycle.
REQ-017 SHALL treat TICK_DIV=1 as incrementing every cycle and SCAN_DIV=1 as advancing the digit every cycle.

Reset
REQ-018 SHALL, while rst=1 (asynchronously), clear count to 0000, clear prescaler and scan divider to 0, set idx to 0, and force ctrl=4'b1111 and segment=8'hFF.
REQ-019 SHALL, on the first rising edge after rst falls, output ctrl=4'b1110 and segment=8'hC0; the count SHALL first reach 0001 TICK_DIV cycles after release.
REQ-020 SHALL, when reset is asserted mid-count, return immediately to the reset state, with nothing retained.

Configuration
REQ-021 SHALL, when macro COUNTER_LEADING_ZERO_BLANK_EN is defined, blank (segment=FF) each leading-zero digit above the most significant non-zero digit; d0 SHALL never be blanked (0000 shows "   0").
REQ-022 SHALL, without COUNTER_LEADING_ZERO_BLANK_EN, show all four digits always, including leading zeros.

Structure
REQ-023 SHALL place the following in shared package counter_pkg: the BCD digit typedef (4 bits), the 10 segment-code constants, the SEG_BLANK constant (FF) and the CTRL_OFF constant (4'b1111).
REQ-024 SHALL implement the decoder as sub-module bcd_to_7seg (4-bit BCD in, 8-bit active-low segments out, combinational), instantiated once on the muxed digit.

Verification
REQ-025 SHALL verify reset: assert rst asynchronously mid-cycle -> ctrl=1111 and segment=FF immediately; release -> next edge ctrl=1110, segment=C0.
REQ-026 SHALL verify counting: TICK_DIV=2 -> count 0001 after 2 cycles and 0010 after 20 cycles; d1 shows F9 when ctrl=1101.
REQ-027 SHALL verify wrap: TICK_DIV=1, run 9999 cycles -> all digits 9 (segment 90 on each ctrl); next cycle -> 0000 (C0 on each).
REQ-028 SHALL verify scanning: SCAN_DIV=4 -> ctrl sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles, and never two bits low at once.
REQ-029 SHALL verify blanking: with COUNTER_LEADING_ZERO_BLANK_EN and count 0042 -> d3,d2 show FF, d1 shows 99, d0 shows A4; without the macro -> d3,d2 show C0.
REQ-030 SHALL verify reset mid-operation: assert rst at count 0573 -> the count after release restarts from 0000.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the four-digit BCD counter with a multiplexed 7-segment display.
package counter_pkg;

  typedef logic [3:0] bcd_t;

  // Active-low segment codes {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] CTRL_OFF = 4'b1111;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam bcd_t BCD_BLANK = 4'hF;

endpackage

// File: rtl/counter_if.sv
// Display bundle for the counter: active-low digit enables and active-low segments.
interface counter_if;
  logic [3:0] ctrl;
  logic [7:0] segment;

  modport master (output ctrl, output segment);
  modport slave  (input ctrl, input segment);
endinterface

// File: rtl/counter_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; any non-BCD code shows a blank digit.
module bcd_to_7seg
  import counter_pkg::*;
(
  input  bcd_t       digit,
  output logic [7:0] segment
);

  always_comb begin
    segment = SEG_BLANK;
    case (digit)
      4'd0: segment = SEG_0;
      4'd1: segment = SEG_1;
      4'd2: segment = SEG_2;
      4'd3: segment = SEG_3;
      4'd4: segment = SEG_4;
      4'd5: segment = SEG_5;
      4'd6: segment = SEG_6;
      4'd7: segment = SEG_7;
      4'd8: segment = SEG_8;
      4'd9: segment = SEG_9;
      default: segment = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/counter.sv
// Four-digit BCD counter driving a scanned 7-segment display with registered outputs.
// Optional leading-zero blanking is enabled by defining COUNTER_LEADING_ZERO_BLANK_EN.
module counter
  import counter_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] ctrl,
  output logic [7:0] segment
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [TW-1:0] pre;
  logic [SW-1:0] scan;
  logic [1:0]    idx;
  bcd_t [3:0]    count;
  bcd_t [3:0]    count_next;
  logic          tick;
  logic          scan_end;
  logic          blank;
  bcd_t          shown;
  logic [7:0]    seg_code;

  assign tick     = (pre == TICK_LAST);
  assign scan_end = (scan == SCAN_LAST);

  // Decimal ripple increment: the carry stops at the first digit below 9.
  always_comb begin
    logic carry;
    carry      = tick;
    count_next = count;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[i] >= BCD_MAX) begin
          count_next[i] = '0;
        end else begin
          count_next[i] = count[i] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

`ifdef COUNTER_LEADING_ZERO_BLANK_EN
  logic lead;

  // A digit is blank only if it and every digit above it are zero; d0 always shows.
  always_comb begin
    lead  = 1'b1;
    blank = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      lead = lead && (count[i] == 4'd0);
      if (idx == 2'(i)) blank = lead;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign shown = blank ? BCD_BLANK : count[idx];

  bcd_to_7seg u_dec (
    .digit   (shown),
    .segment (seg_code)
  );

  // Outputs sample the pre-update count and index, so the display lags state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre     <= '0;
      scan    <= '0;
      idx     <= '0;
      count   <= '0;
      ctrl    <= CTRL_OFF;
      segment <= SEG_BLANK;
    end else begin
      pre     <= tick ? '0 : pre + 1'b1;
      scan    <= scan_end ? '0 : scan + 1'b1;
      count   <= count_next;
      if (scan_end) idx <= idx + 2'd1;
      ctrl    <= ~(4'b0001 << idx);
      segment <= seg_code;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: three parameterisations sharing one clock and reset.
module tb_counter;
  import counter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  counter_if bus_a ();
  counter_if bus_b ();
  counter_if bus_c ();

  counter #(.TICK_DIV(2), .SCAN_DIV(4)) u_a (
    .clk(clk), .rst(rst), .ctrl(bus_a.ctrl), .segment(bus_a.segment)
  );
  counter #(.TICK_DIV(1), .SCAN_DIV(1)) u_b (
    .clk(clk), .rst(rst), .ctrl(bus_b.ctrl), .segment(bus_b.segment)
  );
  counter #(.TICK_DIV(16), .SCAN_DIV(1)) u_c (
    .clk(clk), .rst(rst), .ctrl(bus_c.ctrl), .segment(bus_c.segment)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge k after release shows count and digit index as they stood after edge k-1.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL reset_hold: ctrl=%b seg=%h expected ctrl=1111 seg=ff", bus_a.ctrl, bus_a.segment);
    end
    @(negedge clk) rst = 1'b0;
    step(1);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1110, 8'hC0}) begin
      errors++;
      $display("[TB] FAIL reset_release: ctrl=%b seg=%h expected ctrl=1110 seg=c0", bus_a.ctrl, bus_a.segment);
    end
    step(4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL reset_async: ctrl=%b seg=%h expected ctrl=1111 seg=ff", bus_a.ctrl, bus_a.segment);
    end
    step(1);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL reset_held_edge: ctrl=%b seg=%h expected ctrl=1111 seg=ff", bus_a.ctrl, bus_a.segment);
    end
    @(negedge clk) rst = 1'b0;
    step(1);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1110, 8'hC0}) begin
      errors++;
      $display("[TB] FAIL reset_rerelease: ctrl=%b seg=%h expected ctrl=1110 seg=c0", bus_a.ctrl, bus_a.segment);
    end
  endtask

  task automatic test_counting();
    logic [3:0] exp_ctrl [5] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101};
    logic [7:0] exp_seg  [5] = '{8'hC0, 8'hC0, 8'hF9, 8'h80, 8'hF9};
    int         gap      [5] = '{1, 1, 1, 14, 4};
    restart();
    for (int i = 0; i < 5; i++) begin
      step(gap[i]);
      checks++;
      if ({bus_a.ctrl, bus_a.segment} !== {exp_ctrl[i], exp_seg[i]}) begin
        errors++;
        $display("[TB] FAIL count_%0d: ctrl=%b seg=%h expected ctrl=%b seg=%h",
                 i, bus_a.ctrl, bus_a.segment, exp_ctrl[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_scanning();
    logic [1:0] slot;
    logic [3:0] exp_ctrl;
    restart();
    for (int k = 1; k <= 20; k++) begin
      step(1);
      slot     = 2'((k - 1) / 4);
      exp_ctrl = ~(4'b0001 << slot);
      checks++;
      if (bus_a.ctrl !== exp_ctrl || $countones(~bus_a.ctrl) != 1) begin
        errors++;
        $display("[TB] FAIL scan_edge%0d: ctrl=%b expected ctrl=%b", k, bus_a.ctrl, exp_ctrl);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_ctrl;
    restart();
    step(9997);
    checks++;
    if ({bus_b.ctrl, bus_b.segment} !== {4'b1110, 8'h82}) begin
      errors++;
      $display("[TB] FAIL wrap_9996: ctrl=%b seg=%h expected ctrl=1110 seg=82", bus_b.ctrl, bus_b.segment);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1);
      exp_ctrl = ~(4'b0001 << k);
      checks++;
      if ({bus_b.ctrl, bus_b.segment} !== {exp_ctrl, 8'h90}) begin
        errors++;
        $display("[TB] FAIL wrap_nines_d%0d: ctrl=%b seg=%h expected ctrl=%b seg=90",
                 k, bus_b.ctrl, bus_b.segment, exp_ctrl);
      end
    end
    for (int k = 0; k <= 3; k++) begin
      step(1);
      exp_ctrl = ~(4'b0001 << k);
      checks++;
      if ({bus_b.ctrl, bus_b.segment} !== {exp_ctrl, 8'hC0}) begin
        errors++;
        $display("[TB] FAIL wrap_zero_d%0d: ctrl=%b seg=%h expected ctrl=%b seg=c0",
                 k, bus_b.ctrl, bus_b.segment, exp_ctrl);
      end
    end
  endtask

  task automatic test_blanking();
    logic [7:0] hi;
    logic [7:0] exp_seg [4];
    logic [3:0] exp_ctrl;
`ifdef COUNTER_LEADING_ZERO_BLANK_EN
    hi = 8'hFF;
`else
    hi = 8'hC0;
`endif
    exp_seg = '{8'hA4, 8'h99, hi, hi};
    restart();
    step(672);
    for (int k = 0; k <= 3; k++) begin
      step(1);
      exp_ctrl = ~(4'b0001 << k);
      checks++;
      if ({bus_c.ctrl, bus_c.segment} !== {exp_ctrl, exp_seg[k]}) begin
        errors++;
        $display("[TB] FAIL blank_0042_d%0d: ctrl=%b seg=%h expected ctrl=%b seg=%h",
                 k, bus_c.ctrl, bus_c.segment, exp_ctrl, exp_seg[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    step(1147);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1011, 8'h92}) begin
      errors++;
      $display("[TB] FAIL mid_0573: ctrl=%b seg=%h expected ctrl=1011 seg=92", bus_a.ctrl, bus_a.segment);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1111, 8'hFF}) begin
      errors++;
      $display("[TB] FAIL mid_async: ctrl=%b seg=%h expected ctrl=1111 seg=ff", bus_a.ctrl, bus_a.segment);
    end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    step(1);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1110, 8'hC0}) begin
      errors++;
      $display("[TB] FAIL mid_restart_e1: ctrl=%b seg=%h expected ctrl=1110 seg=c0", bus_a.ctrl, bus_a.segment);
    end
    step(2);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1110, 8'hF9}) begin
      errors++;
      $display("[TB] FAIL mid_restart_e3: ctrl=%b seg=%h expected ctrl=1110 seg=f9", bus_a.ctrl, bus_a.segment);
    end
    step(2);
    checks++;
    if ({bus_a.ctrl, bus_a.segment} !== {4'b1101, 8'hC0}) begin
      errors++;
      $display("[TB] FAIL mid_restart_e5: ctrl=%b seg=%h expected ctrl=1101 seg=c0", bus_a.ctrl, bus_a.segment);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_counting();
    test_scanning();
    test_wrap();
    test_blanking();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
